// File: rtl/group_drain_unit_pkg.sv
// group_drain_unit_pkg: sizing constants and drain FSM state encoding shared with the group control unit
package group_drain_unit_pkg;
  localparam int NUM_GROUPS = 6;
  localparam int IDX_W      = 2;
  localparam int GRP_W      = 3;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/group_drain_unit.sv
// group_drain_unit: snapshots six group fill counts and issues one read request per stored entry
module group_drain_unit
  import group_drain_unit_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [IDX_W-1:0] Index_0,
  input  logic [IDX_W-1:0] Index_1,
  input  logic [IDX_W-1:0] Index_2,
  input  logic [IDX_W-1:0] Index_3,
  input  logic [IDX_W-1:0] Index_4,
  input  logic [IDX_W-1:0] Index_5,
  output logic             Rd_Valid,
  input  logic             Rd_Ready,
  output logic [GRP_W-1:0] Rd_Group,
  output logic [IDX_W-1:0] Rd_Slot,
  output logic             Rd_Last,
  output logic             Busy,
  output logic             Done
);
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [GRP_W-1:0] r_grp;
  logic [IDX_W-1:0] r_slot;
  logic [IDX_W-1:0] r_cnt [NUM_GROUPS];
  logic [IDX_W-1:0] w_cur;
  logic             w_last;
  logic             w_hs;
  logic             w_end_grp;

  assign w_cur     = r_cnt[r_grp];
  assign w_last    = (r_slot == w_cur - 2'd1);
  assign w_hs      = Rd_Valid && Rd_Ready;
  assign w_end_grp = (r_grp == LAST_GRP);

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = Start ? S_SCAN : S_IDLE;
      S_SCAN:  w_next = (w_cur != '0) ? S_EMIT : (w_end_grp ? S_DONE : S_SCAN);
      S_EMIT:  w_next = (w_hs && w_last) ? (w_end_grp ? S_DONE : S_SCAN) : S_EMIT;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from registered state, so Rd_Valid has no path from Rd_Ready
  always_comb begin
    Rd_Valid = (r_state == S_EMIT);
    Rd_Last  = (r_state == S_EMIT) && w_last;
    Busy     = (r_state != S_IDLE);
    Done     = (r_state == S_DONE);
    Rd_Group = r_grp;
    Rd_Slot  = r_slot;
  end

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_grp  <= '0;
      r_slot <= '0;
      r_cnt  <= '{default: '0};
    end else if (r_state == S_IDLE && Start) begin
      r_grp  <= '0;
      r_slot <= '0;
      r_cnt  <= '{Index_0, Index_1, Index_2, Index_3, Index_4, Index_5};
    end else if (r_state == S_SCAN && w_cur == '0 && !w_end_grp) begin
      r_grp  <= r_grp + 3'd1;
    end else if (r_state == S_EMIT && w_hs) begin
      r_slot <= w_last ? '0 : r_slot + 2'd1;
      r_grp  <= (w_last && !w_end_grp) ? r_grp + 3'd1 : r_grp;
    end
endmodule
